// File: rtl/piano_pkg.sv
// Shared note-index constants, base-octave pitch table and half-period helper
// for the piano datapath (auto player, keyboard, learn mode and tone_gen).
package piano_pkg;

   localparam int NOTE_W   = 5;
   localparam int HP_MIN_W = 18;

   localparam logic [NOTE_W-1:0] NOTE_REST = 5'd0;
   localparam logic [NOTE_W-1:0] NOTE_C4   = 5'd1;
   localparam logic [NOTE_W-1:0] NOTE_D4   = 5'd2;
   localparam logic [NOTE_W-1:0] NOTE_E4   = 5'd3;
   localparam logic [NOTE_W-1:0] NOTE_F4   = 5'd4;
   localparam logic [NOTE_W-1:0] NOTE_G4   = 5'd5;
   localparam logic [NOTE_W-1:0] NOTE_A4   = 5'd6;
   localparam logic [NOTE_W-1:0] NOTE_B4   = 5'd7;
   localparam logic [NOTE_W-1:0] NOTE_C5   = 5'd8;
   localparam logic [NOTE_W-1:0] NOTE_D5   = 5'd9;
   localparam logic [NOTE_W-1:0] NOTE_E5   = 5'd10;
   localparam logic [NOTE_W-1:0] NOTE_F5   = 5'd11;
   localparam logic [NOTE_W-1:0] NOTE_G5   = 5'd12;
   localparam logic [NOTE_W-1:0] NOTE_A5   = 5'd13;
   localparam logic [NOTE_W-1:0] NOTE_B5   = 5'd14;
   localparam logic [NOTE_W-1:0] NOTE_C6   = 5'd15;
   localparam logic [NOTE_W-1:0] NOTE_D6   = 5'd16;
   localparam logic [NOTE_W-1:0] NOTE_E6   = 5'd17;
   localparam logic [NOTE_W-1:0] NOTE_F6   = 5'd18;
   localparam logic [NOTE_W-1:0] NOTE_G6   = 5'd19;
   localparam logic [NOTE_W-1:0] NOTE_A6   = 5'd20;
   localparam logic [NOTE_W-1:0] NOTE_B6   = 5'd21;
   localparam logic [NOTE_W-1:0] NOTE_MAX  = 5'd21;

   localparam int unsigned BASE_HZ [8] = '{262, 294, 330, 349, 392, 440, 494, 0};

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_TONE = 1'b1
   } tone_state_e;

   // Rest and out-of-range indices map to 0; only evaluated at elaboration.
   function automatic int unsigned half_period(input int unsigned note,
                                               input int unsigned clk_hz);
      int unsigned oct;
      int unsigned idx;
      int unsigned freq;
      if (note == 0 || note > 32'(NOTE_MAX)) return 0;
      oct  = (note - 1) / 7;
      idx  = (note - 1) % 7;
      freq = BASE_HZ[idx[2:0]] << oct;
      return clk_hz / (2 * freq);
   endfunction

endpackage

// File: rtl/tone_gen_if.sv
// Note/volume request in, speaker waveform and status out; state is exposed
// for checkers.
interface tone_gen_if;
   import piano_pkg::*;

   logic [NOTE_W-1:0] note;
   logic [1:0]        vol;
   logic              speaker;
   logic              active;
   logic              period_tick;
   tone_state_e       state;

   // No handshake: note/vol are level inputs sampled every clock; the outputs
   // are registered levels, period_tick a single-cycle pulse.
   modport master (
      output note, vol,
      input  speaker, active, period_tick, state
   );

   modport slave (
      input  note, vol,
      output speaker, active, period_tick, state
   );
endinterface

// File: rtl/tone_gen_vol_pwm.sv
// Free-running volume PWM carrier; the gate is decoded from the next carrier
// value so the registered speaker lines up with the registered counter.
module vol_pwm #(
   parameter int PWM_BITS = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] vol,
   output logic       gate_next
);

   localparam logic [PWM_BITS-1:0] QUARTER = PWM_BITS'(1 << (PWM_BITS - 2));
   localparam logic [PWM_BITS-1:0] HALF    = PWM_BITS'(1 << (PWM_BITS - 1));

   logic [PWM_BITS-1:0] pwm_cnt_q;
   logic [PWM_BITS-1:0] pwm_cnt_d;

   always_comb begin
      pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
      gate_next = 1'b0;
      case (vol)
         2'd0:    gate_next = 1'b0;
         2'd1:    gate_next = (pwm_cnt_d < QUARTER);
         2'd2:    gate_next = (pwm_cnt_d < HALF);
         default: gate_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pwm_cnt_q <= '0;
      else        pwm_cnt_q <= pwm_cnt_d;
   end

endmodule

// File: rtl/tone_gen.sv
// Note-to-square-wave generator: pitch changes take effect only at period
// boundaries, rests cut the tone immediately, volume gates the high phase.
module tone_gen
   import piano_pkg::*;
#(
   parameter int unsigned CLK_HZ   = 100_000_000,
   parameter int          PWM_BITS = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   tone_gen_if.slave  bus
);

   localparam int HP_REQ = $clog2(half_period(1, CLK_HZ) + 1);
   localparam int HP_W   = (HP_REQ > HP_MIN_W) ? HP_REQ : HP_MIN_W;

   logic [HP_W-1:0] hp_tab [32];

   for (genvar g = 0; g < 32; g++) begin : g_hp_tab
      assign hp_tab[g] = HP_W'(half_period(g, CLK_HZ));
   end

   tone_state_e       state_q, state_d;
   logic [NOTE_W-1:0] cur_note_q, cur_note_d;
   logic [HP_W-1:0]   half_cnt_q, half_cnt_d;
   logic              phase_q, phase_d;
   logic              speaker_q, speaker_d;
   logic              active_q, active_d;
   logic              tick_q, tick_d;
   logic              gate_next;
   logic              note_valid;
   logic [HP_W-1:0]   hp_cur;

   vol_pwm #(.PWM_BITS(PWM_BITS)) u_vol_pwm (
      .clk       (clk),
      .rst_n     (rst_n),
      .vol       (bus.vol),
      .gate_next (gate_next)
   );

   assign note_valid = (bus.note != NOTE_REST) && (bus.note <= NOTE_MAX);
   assign hp_cur     = hp_tab[cur_note_q];

   always_comb begin
      state_d    = state_q;
      cur_note_d = cur_note_q;
      half_cnt_d = half_cnt_q;
      phase_d    = phase_q;
      tick_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            half_cnt_d = '0;
            phase_d    = 1'b0;
            if (note_valid) begin
               state_d    = ST_TONE;
               cur_note_d = bus.note;
               phase_d    = 1'b1;
            end
         end
         ST_TONE: begin
            if (!note_valid) begin
               state_d    = ST_IDLE;
               cur_note_d = NOTE_REST;
               half_cnt_d = '0;
               phase_d    = 1'b0;
            end else if (half_cnt_q == hp_cur - HP_W'(1)) begin
               half_cnt_d = '0;
               phase_d    = ~phase_q;
               // Low->high is the only point where a new pitch is accepted.
               if (!phase_q) begin
                  tick_d     = 1'b1;
                  cur_note_d = bus.note;
               end
            end else begin
               half_cnt_d = half_cnt_q + HP_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      speaker_d = phase_d & gate_next;
      active_d  = (state_d == ST_TONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cur_note_q <= NOTE_REST;
         half_cnt_q <= '0;
         phase_q    <= 1'b0;
         speaker_q  <= 1'b0;
         active_q   <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_note_q <= cur_note_d;
         half_cnt_q <= half_cnt_d;
         phase_q    <= phase_d;
         speaker_q  <= speaker_d;
         active_q   <= active_d;
         tick_q     <= tick_d;
      end
   end

   assign bus.speaker     = speaker_q;
   assign bus.active      = active_q;
   assign bus.period_tick = tick_q;
   assign bus.state       = state_q;

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen at a scaled-down clock (100 kHz, 4-bit PWM)
// so every pitch period is short; expected half-periods are hand-computed.
module tb_tone_gen;
   import piano_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   fails = 0;
   logic [31:0] exp_q[$];

   tone_gen_if bus ();

   tone_gen #(.CLK_HZ(100_000), .PWM_BITS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Length of the current speaker level, counting the present cycle.
   task automatic run_len(output int n);
      logic level;
      level = bus.speaker;
      n = 0;
      while (bus.speaker === level && n < 1000) begin
         n++;
         tick();
      end
   endtask

   // scoreboard: measured alternating run lengths against the expected queue
   task automatic expect_runs(input string tag);
      int n;
      while (exp_q.size() > 0) begin
         run_len(n);
         check(tag, n, exp_q.pop_front());
      end
   endtask

   task automatic count_high(input int cycles, output int hi, output int act);
      hi = 0;
      act = 0;
      for (int i = 0; i < cycles; i++) begin
         if (bus.speaker === 1'b1) hi++;
         if (bus.active === 1'b1) act++;
         tick();
      end
   endtask

   initial begin
      int n;
      int hi;
      int act;
      bus.note = NOTE_REST;
      bus.vol  = 2'd3;

      // reset state
      #3;
      check("rst_speaker", bus.speaker, 0);
      check("rst_active", bus.active, 0);
      check("rst_tick", bus.period_tick, 0);
      check("rst_state", 32'(bus.state), 32'(ST_IDLE));
      tick();
      rst_n = 1'b1;
      ticks(3);

      // rest -> note 8 (HP 95)
      bus.note = NOTE_C5;
      tick();
      check("entry_speaker", bus.speaker, 1);
      check("entry_active", bus.active, 1);
      check("entry_no_tick", bus.period_tick, 0);
      exp_q = '{95, 95};
      expect_runs("c5_half");
      check("c5_tick", bus.period_tick, 1);
      n = 1;
      tick();
      check("c5_tick_pulse", bus.period_tick, 0);
      while (bus.period_tick !== 1'b1 && n < 1000) begin
         n++;
         tick();
      end
      check("c5_period", n, 190);

      // 8 -> 13 mid-high: old period completes, then HP 56
      ticks(10);
      bus.note = NOTE_A5;
      exp_q = '{85, 95, 56, 56};
      expect_runs("c5_to_a5");

      // 1 -> 3 -> 5 inside one period: only note 5 (HP 127) is heard
      bus.note = NOTE_C4;
      ticks(5);
      bus.note = NOTE_E4;
      ticks(5);
      bus.note = NOTE_G4;
      exp_q = '{46, 56, 127, 127};
      expect_runs("deferred_g4");

      // note 6 (HP 113), then rest mid-high
      bus.note = NOTE_A4;
      exp_q = '{127, 127, 113};
      expect_runs("g4_to_a4");
      check("a4_low_no_tick", bus.period_tick, 0);
      exp_q = '{113};
      expect_runs("a4_low");
      check("a4_tick", bus.period_tick, 1);
      ticks(3);
      bus.note = NOTE_REST;
      tick();
      check("rest_speaker", bus.speaker, 0);
      check("rest_active", bus.active, 0);
      check("rest_state", 32'(bus.state), 32'(ST_IDLE));
      n = 0;
      for (int i = 0; i < 50; i++) begin
         if (bus.period_tick !== 1'b0 || bus.speaker !== 1'b0) n++;
         tick();
      end
      check("idle_quiet", n, 0);

      // invalid note 25 behaves as rest
      bus.note = NOTE_A4;
      tick();
      check("reentry_speaker", bus.speaker, 1);
      check("reentry_no_tick", bus.period_tick, 0);
      ticks(3);
      bus.note = 5'd25;
      tick();
      check("inv_speaker", bus.speaker, 0);
      check("inv_active", bus.active, 0);

      // volume 25 %: 7 carriers of 16 inside one high phase
      bus.vol  = 2'd1;
      bus.note = NOTE_A4;
      tick();
      count_high(112, hi, act);
      check("vol1_high", hi, 28);
      check("vol1_active", act, 112);
      bus.vol = 2'd0;
      tick();
      count_high(300, hi, act);
      check("vol0_high", hi, 0);
      check("vol0_active", act, 300);

      // volume 50 %
      bus.note = NOTE_REST;
      tick();
      bus.vol  = 2'd2;
      bus.note = NOTE_A4;
      tick();
      count_high(112, hi, act);
      check("vol2_high", hi, 56);

      // asynchronous reset mid-high, restart on note 15 (HP 47)
      bus.note = NOTE_REST;
      tick();
      bus.vol  = 2'd3;
      bus.note = NOTE_C5;
      tick();
      check("pre_rst_speaker", bus.speaker, 1);
      ticks(5);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_speaker", bus.speaker, 0);
      check("async_rst_active", bus.active, 0);
      bus.note = NOTE_C6;
      ticks(2);
      rst_n = 1'b1;
      tick();
      check("restart_speaker", bus.speaker, 1);
      check("restart_active", bus.active, 1);
      exp_q = '{47, 47};
      expect_runs("c6_half");
      check("c6_tick", bus.period_tick, 1);

      // final report
      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
